// File: rtl/xbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xbar_pkg
// Description : Shared types and width helpers for the crossbar grant
//               controller and its round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package xbar_pkg;

  // Per-master grant FSM: waiting for a request, or holding a packet lock
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index width for an n-entry vector, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xbar_grant_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches the request vector
//               starting one above the pointer, wrapping N-1 -> 0, and
//               returns the winner as both one-hot and index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_oh_o,
  output logic [IW-1:0] grant_idx_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IW:0]    start;
  logic           found;
  int             sum;

  // Rotate requests so the search origin sits at bit 0, take the first set
  // bit, then map the rotated offset back to an absolute slave index.
  always_comb begin
    start       = {1'b0, ptr_i} + (IW+1)'(1);
    req_dbl     = {req_i, req_i} >> start;
    req_rot     = req_dbl[N-1:0];
    found       = 1'b0;
    sum         = 0;
    grant_idx_o = '0;
    grant_oh_o  = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        sum   = int'(start) + k;
      end
    end
    if (sum >= N) begin
      sum = sum - N;
    end
    if (found) begin
      grant_idx_o = IW'(sum);
    end
    for (int i = 0; i < N; i++) begin
      grant_oh_o[i] = found && (grant_idx_o == IW'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/xbar_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xbar_grant_ctrl
// Description : Packet-granular grant controller for an S x M stream
//               crossbar. Each master owns an IDLE/BUSY FSM that locks one
//               slave for a whole packet and exports the mux select m_id_o.
// Revision    : 1.0 - initial release
// ============================================================================
module xbar_grant_ctrl
  import xbar_pkg::*;
#(
  parameter  int S_DATA_COUNT = 2,
  parameter  int M_DATA_COUNT = 3,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [M_DATA_COUNT-1:0]              m_ready_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [M_DATA_COUNT-1:0]              m_valid_o,
  output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o
);

  localparam int IW = T_ID___WIDTH;
  localparam int DW = T_DEST_WIDTH;

  logic [M_DATA_COUNT-1:0] busy;
  logic [IW-1:0]           id_w [M_DATA_COUNT];
  logic [S_DATA_COUNT-1:0] locked;

  // A slave is locked while any BUSY master selects it; ready is passed
  // back only from that owning master.
  always_comb begin
    locked    = '0;
    s_ready_o = '0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        if (busy[j] && (id_w[j] == IW'(i))) begin
          locked[i]    = 1'b1;
          s_ready_o[i] = m_ready_i[j];
        end
      end
    end
  end

  for (genvar j = 0; j < M_DATA_COUNT; j++) begin : g_master
    state_e                  state_q, state_d;
    logic [IW-1:0]           id_q, id_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [S_DATA_COUNT-1:0] req;
    logic [S_DATA_COUNT-1:0] grant_oh;
    logic [IW-1:0]           grant_idx;
    logic                    valid;

    // Requests: unlocked valid slaves whose destination is this master.
    // Out-of-range destinations match no master and are never granted.
    always_comb begin
      req = '0;
      for (int i = 0; i < S_DATA_COUNT; i++) begin
        req[i] = s_valid_i[i] && (s_dest_i[i*DW +: DW] == DW'(j)) && !locked[i];
      end
    end

    rr_arbiter #(
      .N (S_DATA_COUNT)
    ) u_rr (
      .req_i       (req),
      .ptr_i       (ptr_q),
      .grant_oh_o  (grant_oh),
      .grant_idx_o (grant_idx)
    );

    assign busy[j]                 = (state_q == BUSY);
    assign valid                   = busy[j] && s_valid_i[id_q];
    assign m_valid_o[j]            = valid;
    assign id_w[j]                 = id_q;
    assign m_id_o[j*IW +: IW]      = id_q;

    // Next state: grant from IDLE, release on the last transferred beat
    always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      case (state_q)
        IDLE: begin
          if (|grant_oh) begin
            id_d    = grant_idx;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (valid && m_ready_i[j] && s_last_i[id_q]) begin
            ptr_d   = id_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // State registers; reset pointer makes slave 0 the first winner
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        id_q    <= '0;
        ptr_q   <= IW'(S_DATA_COUNT - 1);
      end else begin
        state_q <= state_d;
        id_q    <= id_d;
        ptr_q   <= ptr_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/xbar_grant_ctrl.md
XBAR_GRANT_CTRL -- requirements
Module: xbar_grant_ctrl

Interface
REQ-001 The block SHALL have parameter S_DATA_COUNT, default 2: number of slave (input) streams; legal range >= 2.
REQ-002 The block SHALL have parameter M_DATA_COUNT, default 3: number of master (output) streams; legal range >= 2.
REQ-003 The block SHALL have localparam T_ID___WIDTH = $clog2(S_DATA_COUNT): slave-index width.
REQ-004 The block SHALL have localparam T_DEST_WIDTH = $clog2(M_DATA_COUNT): destination width.
REQ-005 The block SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have port s_valid_i, input, [S_DATA_COUNT-1:0]: per-slave beat valid.
REQ-008 The block SHALL have port s_dest_i, input, [T_DEST_WIDTH-1:0] x S_DATA_COUNT: per-slave target master.
REQ-009 The block SHALL have port s_last_i, input, [S_DATA_COUNT-1:0]: per-slave last beat of packet.
REQ-010 The block SHALL have port m_ready_i, input, [M_DATA_COUNT-1:0]: per-master downstream ready.
REQ-011 The block SHALL have port s_ready_o, output, [S_DATA_COUNT-1:0]: per-slave ready.
REQ-012 The block SHALL have port m_valid_o, output, [M_DATA_COUNT-1:0]: per-master valid.
REQ-013 The block SHALL have port m_id_o, output, [T_ID___WIDTH-1:0] x M_DATA_COUNT: granted slave index per master; this is the select consumed by the crossbar data/last mux.

Function
REQ-014 Each master j SHALL run an independent FSM with states IDLE and BUSY.
REQ-015 In IDLE, request vector req_j[i] SHALL be s_valid_i[i] && (s_dest_i[i] == j) && slave i not locked to any master.
REQ-016 In IDLE with req_j != 0, the FSM SHALL pick the winner round-robin, searching from rr_ptr_j+1 upward with wrap at S_DATA_COUNT-1 -> 0, register it into m_id_o[j], lock slave i to j, and enter BUSY at the next edge.
REQ-017 Latency: first beat of a packet SHALL be transferable 1 cycle after valid+dest is first presented to an IDLE master.
REQ-018 When two masters' IDLE FSMs would grant the same slave in one cycle, only the master matching s_dest_i SHALL grant; the other sees no request (dest is unique per slave).
REQ-019 In BUSY, m_valid_o[j] SHALL equal s_valid_i[m_id_o[j]] and s_ready_o[m_id_o[j]] SHALL equal m_ready_i[j], both combinational.
REQ-020 A beat SHALL transfer when m_valid_o[j] && m_ready_i[j]; on transfer with s_last_i[m_id_o[j]]=1 the FSM SHALL set rr_ptr_j = m_id_o[j], unlock the slave and return to IDLE at the next edge.
REQ-021 Mid-packet s_valid_i deassertion SHALL NOT release the lock; BUSY holds until the last beat transfers.
REQ-022 s_dest_i of a locked slave SHALL be ignored until unlock.
REQ-023 In IDLE, m_valid_o[j] SHALL be 0; m_id_o[j] SHALL hold its last value.
REQ-024 s_ready_o[i] SHALL be 0 whenever slave i is not locked.
REQ-025 s_dest_i[i] >= M_DATA_COUNT SHALL never be granted; the slave stalls with s_ready_o[i]=0.
REQ-026 Back-to-back packets to one master SHALL incur exactly one IDLE bubble cycle.

Reset
REQ-027 While rst_n=0: all FSMs IDLE, all locks clear, m_valid_o=0, s_ready_o=0, m_id_o[*]=0, rr_ptr_j=S_DATA_COUNT-1 (slave 0 has first priority).
REQ-028 Reset asserted mid-packet SHALL abort all packets immediately with no completion beat; operation resumes from REQ-027 state on the first edge after release.

Structure
REQ-029 Package xbar_pkg SHALL hold the FSM state enum (IDLE, BUSY) and shared width helpers; the module SHALL import it.
REQ-030 The round-robin pick SHALL be a sub-module rr_arbiter (request vector + pointer in, one-hot/index grant out), instantiated once per master via generate.

Verification
REQ-031 Reset: hold rst_n=0 with all s_valid_i=1 -> m_valid_o=0, s_ready_o=0, m_id_o[*]=0.
REQ-032 Single packet: slave 1, dest 2, 3 beats, m_ready_i=all 1 -> m_id_o[2]=1 one cycle later, 3 transfers, IDLE after last.
REQ-033 Contention: slaves 0 and 1 both dest 0 continuously with 2-beat packets -> grants alternate 0,1,0,1 with one bubble between packets.
REQ-034 Parallel: slave 0 dest 1, slave 1 dest 0 simultaneously -> both masters BUSY in same cycle, m_id_o[1]=0, m_id_o[0]=1.
REQ-035 Backpressure/hole: m_ready_i[0]=0 for 4 cycles and s_valid_i drop mid-packet -> no transfer, lock held, m_id_o stable.
REQ-036 Reset mid-packet and illegal dest 3 (M=3) -> locks cleared; dest-3 slave never granted, s_ready_o stays 0.
